// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 LED output path: pixel width, default
// 25 MHz bit timing, and the serializer state encoding.
package ws2812_pkg;

  localparam int unsigned PIXEL_W = 24;

  // Default timing in clk cycles at 25 MHz (40 ns per cycle).
  localparam int unsigned DEF_T0H     = 10;
  localparam int unsigned DEF_T1H     = 20;
  localparam int unsigned DEF_T_BIT   = 31;
  localparam int unsigned DEF_T_RESET = 7500;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } ws_state_t;

  // High time of one data bit for the given bit value.
  function automatic int unsigned high_time(input logic bit_val,
                                            input int unsigned t0h,
                                            input int unsigned t1h);
    return bit_val ? t1h : t0h;
  endfunction

endpackage

// File: rtl/ws2812_serializer.sv
// Serializes 24-bit GRB pixels MSB-first onto a WS2812 data line with
// pulse-width-coded bits, and drives the line low for the latch interval on request.
module ws2812_serializer
  import ws2812_pkg::*;
#(
  parameter int unsigned T0H     = DEF_T0H,
  parameter int unsigned T1H     = DEF_T1H,
  parameter int unsigned T_BIT   = DEF_T_BIT,
  parameter int unsigned T_RESET = DEF_T_RESET
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIXEL_W-1:0] pixel_data,
  input  logic               pixel_valid,
  output logic               pixel_ready,
  input  logic               latch,
  output logic               busy,
  output logic               led_out
);

  localparam int unsigned CNT_W = $clog2(T_RESET + 1);

  localparam logic [CNT_W-1:0] T0H_C      = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] T1H_C      = CNT_W'(T1H);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(T_BIT - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(T_RESET - 1);
  localparam logic [4:0]       IDX_LAST   = 5'(PIXEL_W - 1);

  ws_state_t          state_q, state_d;
  logic [PIXEL_W-1:0] shift_q, shift_d;
  logic [4:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               led_d;
  logic               last_cycle;
  logic               accept;

  assign last_cycle = (state_q == SEND) && (idx_q == IDX_LAST) && (cnt_q == BIT_LAST);

  always_comb begin
    pixel_ready = !pend_q && ((state_q == IDLE) || last_cycle);
    accept      = pixel_valid && pixel_ready;
    busy        = (state_q != IDLE) || pend_q;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;

    // Requests during LATCH are absorbed so the low time is never extended.
    if (latch && (state_q != LATCH)) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          shift_d = pixel_data;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (pend_q || latch) begin
          state_d = LATCH;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      end

      SEND: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            if (accept) begin
              shift_d = pixel_data;
              idx_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shift_d = {shift_q[PIXEL_W-2:0], 1'b0};
            idx_d   = idx_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The line level is derived from next-cycle state so the registered output
  // goes high in the first cycle after the accept edge.
  always_comb begin
    led_d = 1'b0;
    if (state_d == SEND) begin
      led_d = cnt_d < (shift_d[PIXEL_W-1] ? T1H_C : T0H_C);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      led_out <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      led_out <= led_d;
    end
  end

endmodule
